// File: rtl/regfile_readback_scan_pkg.sv
// Shared constants for the register-file readback scanner.
// Register geometry, scan FSM state codes and default Fibonacci seeds.
package regfile_readback_scan_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_W    = 16;
    localparam int IDX_W    = $clog2(NUM_REGS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    // Scan FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEL   = 2'd1;
    localparam logic [1:0] ST_DWELL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Seeds shared with the writer-side Fibonacci test FSM
    localparam logic [REG_W-1:0] DEFAULT_SEED0 = 16'h0001;
    localparam logic [REG_W-1:0] DEFAULT_SEED1 = 16'h0001;

endpackage

// File: rtl/regfile_readback_scan_hex7seg.sv
// hexTo7Seg: one hex nibble to an active-high seven-segment pattern.
// Bit order is {g,f,e,d,c,b,a}.
module hexTo7Seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure lookup, one pattern per nibble value
    always_comb begin
        seg = 7'h00;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/regfile_readback_scan.sv
// Passive readback scan of r0..r15 onto a four-digit display.
// Optional Fibonacci check is built when READBACK_CHECK_EN is defined.
module regfile_readback_scan
    import regfile_readback_scan_pkg::*;
#(
    parameter int               DWELL_CYCLES = 2,
    parameter logic [REG_W-1:0] SEED0        = DEFAULT_SEED0,
    parameter logic [REG_W-1:0] SEED1        = DEFAULT_SEED1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [REG_W-1:0] rdata,
    output logic [IDX_W-1:0] rsel,
    output logic [REG_W-1:0] shown_value,
    output logic [IDX_W-1:0] shown_index,
    output logic [27:0]      display,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [IDX_W-1:0] mismatch_index
);

    // A zero dwell would skip the hold entirely; clamp it to one cycle.
    localparam int DW    = (DWELL_CYCLES < 1) ? 1 : DWELL_CYCLES;
    localparam int CNT_W = $clog2(DW) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DW - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] rsel_q, rsel_d;
    logic [REG_W-1:0] shown_value_q, shown_value_d;
    logic [IDX_W-1:0] shown_index_q, shown_index_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic start_ok;
    logic capture;

    assign start_ok = start &&
                      (state_q == ST_IDLE || state_q == ST_DONE);
    assign capture  = (state_q == ST_SEL);

    // Scan FSM: step rsel, capture on the settled cycle, then dwell
    always_comb begin
        state_d       = state_q;
        rsel_d        = rsel_q;
        shown_value_d = shown_value_q;
        shown_index_d = shown_index_q;
        cnt_d         = cnt_q;
        done_d        = done_q;
        if (start_ok) begin
            state_d = ST_SEL;
            rsel_d  = '0;
            done_d  = 1'b0;
        end else if (capture) begin
            shown_value_d = rdata;
            shown_index_d = rsel_q;
            cnt_d         = CNT_LOAD;
            state_d       = ST_DWELL;
        end else if (state_q == ST_DWELL) begin
            if (cnt_q == '0) begin
                if (rsel_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    rsel_d  = rsel_q + 1'b1;
                    state_d = ST_SEL;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Scan state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rsel_q        <= '0;
            shown_value_q <= '0;
            shown_index_q <= '0;
            cnt_q         <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rsel_q        <= rsel_d;
            shown_value_q <= shown_value_d;
            shown_index_q <= shown_index_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
        end
    end

    assign rsel        = rsel_q;
    assign shown_value = shown_value_q;
    assign shown_index = shown_index_q;
    assign done        = done_q;
    assign busy        = (state_q == ST_SEL) || (state_q == ST_DWELL);

`ifdef READBACK_CHECK_EN
    logic [REG_W-1:0] exp_a_q, exp_a_d;
    logic [REG_W-1:0] exp_b_q, exp_b_d;
    logic             mm_q, mm_d;
    logic [IDX_W-1:0] mmi_q, mmi_d;

    // Fibonacci generator advances once per capture; first miss is sticky
    always_comb begin
        exp_a_d = exp_a_q;
        exp_b_d = exp_b_q;
        mm_d    = mm_q;
        mmi_d   = mmi_q;
        if (start_ok) begin
            exp_a_d = SEED0;
            exp_b_d = SEED1;
            mm_d    = 1'b0;
            mmi_d   = '0;
        end else if (capture) begin
            if (rdata != exp_a_q && !mm_q) begin
                mm_d  = 1'b1;
                mmi_d = rsel_q;
            end
            exp_a_d = exp_b_q;
            exp_b_d = exp_a_q + exp_b_q;
        end
    end

    // Checker registers
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_a_q <= SEED0;
            exp_b_q <= SEED1;
            mm_q    <= 1'b0;
            mmi_q   <= '0;
        end else begin
            exp_a_q <= exp_a_d;
            exp_b_q <= exp_b_d;
            mm_q    <= mm_d;
            mmi_q   <= mmi_d;
        end
    end

    assign mismatch       = mm_q;
    assign mismatch_index = mmi_q;
`else
    logic unused_seeds;
    assign unused_seeds   = ^{SEED0, SEED1};
    assign mismatch       = 1'b0;
    assign mismatch_index = '0;
`endif

    hexTo7Seg u_dig3 (.hex(shown_value_q[15:12]), .seg(display[27:21]));
    hexTo7Seg u_dig2 (.hex(shown_value_q[11:8]),  .seg(display[20:14]));
    hexTo7Seg u_dig1 (.hex(shown_value_q[7:4]),   .seg(display[13:7]));
    hexTo7Seg u_dig0 (.hex(shown_value_q[3:0]),   .seg(display[6:0]));

endmodule

// File: tb/tb_regfile_readback_scan.sv
// Self-checking bench for regfile_readback_scan (D=2 and zero-dwell DUTs).
// Timing-formula reference model plus directed and random scans.
module tb_regfile_readback_scan;

`ifdef READBACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [6:0] SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [15:0] mem [16];

    always #5 clk = ~clk;

    logic [3:0]  rsel_a, si_a, mmi_a, rsel_b, si_b, mmi_b;
    logic [15:0] rdata_a, rdata_b, sv_a, sv_b;
    logic [27:0] disp_a, disp_b;
    logic        busy_a, done_a, mm_a, busy_b, done_b, mm_b;

    assign rdata_a = mem[rsel_a];
    assign rdata_b = mem[rsel_b];

    regfile_readback_scan #(.DWELL_CYCLES(2)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .rdata(rdata_a),
        .rsel(rsel_a), .shown_value(sv_a), .shown_index(si_a),
        .display(disp_a), .busy(busy_a), .done(done_a),
        .mismatch(mm_a), .mismatch_index(mmi_a));

    regfile_readback_scan #(.DWELL_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .rdata(rdata_b),
        .rsel(rsel_b), .shown_value(sv_b), .shown_index(si_b),
        .display(disp_b), .busy(busy_b), .done(done_b),
        .mismatch(mm_b), .mismatch_index(mmi_b));

    int errors = 0;
    int checks = 0;

    function automatic int dw(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    function automatic logic [15:0] fib(input int i);
        logic [15:0] a, b, t;
        a = 16'd1;
        b = 16'd1;
        for (int k = 0; k < i; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [27:0] seg4(input logic [15:0] v);
        return {SEG[v[15:12]], SEG[v[11:8]], SEG[v[7:4]], SEG[v[3:0]]};
    endfunction

    // Reference model: cycles since accepted start -> scan position
    int          m_k    [2];
    bit          m_busy [2];
    bit          m_done [2];
    bit          m_mm   [2];
    logic [3:0]  m_mmi  [2];
    logic [3:0]  m_li   [2];
    logic [15:0] m_lv   [2];
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            int d;
            int i;
            d = dw(u);
            if (reset) begin
                m_k[u] = 0; m_busy[u] = 0; m_done[u] = 0;
                m_mm[u] = 0; m_mmi[u] = 0; m_li[u] = 0; m_lv[u] = 0;
            end else if (!m_busy[u] && start) begin
                m_k[u] = 0; m_busy[u] = 1; m_done[u] = 0;
                m_mm[u] = 0; m_mmi[u] = 0;
            end else if (m_busy[u]) begin
                m_k[u]++;
                if ((m_k[u] - 1) % (d + 1) == 0) begin
                    i = (m_k[u] - 1) / (d + 1);
                    m_lv[u] = mem[i];
                    m_li[u] = 4'(i);
                    if (CHK && mem[i] != fib(i) && !m_mm[u]) begin
                        m_mm[u] = 1;
                        m_mmi[u] = 4'(i);
                    end
                end
                if (m_k[u] == 16 * (d + 1)) begin
                    m_busy[u] = 0;
                    m_done[u] = 1;
                end
            end
        end
        model_ok = 1'b1;
    end

    function automatic logic [66:0] model_out(input int u);
        logic [3:0] r;
        if (m_busy[u]) r = 4'(m_k[u] / (dw(u) + 1));
        else           r = m_done[u] ? 4'd15 : 4'd0;
        return {r, m_lv[u], m_li[u], seg4(m_lv[u]), m_busy[u],
                m_done[u], m_mm[u], m_mmi[u]};
    endfunction

    // Every-cycle compare of both DUTs against the model
    always @(negedge clk) begin
        if (model_ok) begin
            logic [66:0] ga, gb, ea, eb;
            ga = {rsel_a, sv_a, si_a, disp_a, busy_a, done_a, mm_a, mmi_a};
            gb = {rsel_b, sv_b, si_b, disp_b, busy_b, done_b, mm_b, mmi_b};
            ea = model_out(0);
            eb = model_out(1);
            checks += 2;
            if (ga !== ea) begin
                errors++;
                $display("FAIL cycle_a t=%0t got=%h want=%h", $time, ga, ea);
            end
            if (gb !== eb) begin
                errors++;
                $display("FAIL cycle_b t=%0t got=%h want=%h", $time, gb, eb);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_fib();
        for (int i = 0; i < 16; i++) mem[i] = fib(i);
    endtask

    task automatic run_to_done(output int na, output int nb);
        na = -1;
        nb = -1;
        for (int n = 1; n <= 120; n++) begin
            tick();
            if (done_a && na < 0) na = n;
            if (done_b && nb < 0) nb = n;
            if (na >= 0 && nb >= 0) break;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy_a || busy_b) && t < 150) begin
            tick();
            t++;
        end
        chk("idle_wait", 32'(busy_a || busy_b), 32'd0);
    endtask

    int na, nb, n;
    bit pulsed;

    initial begin
        load_fib();
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_disp", 32'(disp_a), 32'({4{7'h3F}}));
        chk("rst_busy", 32'(busy_a), 32'd0);
        reset = 1'b0;
        tick();

        // Nominal scan
        pulse_start();
        run_to_done(na, nb);
        chk("done_cyc_a", 32'(na), 32'd48);
        chk("done_cyc_b", 32'(nb), 32'd32);
        chk("final_val", 32'(sv_a), 32'h03DB);
        chk("final_idx", 32'(si_a), 32'd15);
        chk("final_disp", 32'(disp_a),
            32'({7'h3F, 7'h4F, 7'h5E, 7'h7C}));
        chk("nom_mm", 32'(mm_a), 32'd0);

        // Single corruption at r7
        mem[7] = 16'h0016;
        pulse_start();
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 21) chk("mm_pre7", 32'(mm_a), 32'd0);
            if (k == 22) chk("mm_at7", 32'(mm_a), 32'(CHK));
            if (done_a) break;
        end
        chk("c1_done", 32'(done_a), 32'd1);
        chk("c1_idx_a", 32'(mmi_a), CHK ? 32'd7 : 32'd0);
        chk("c1_idx_b", 32'(mmi_b), CHK ? 32'd7 : 32'd0);

        // Multiple corruptions, first one wins
        load_fib();
        mem[3] = 16'h0009;
        mem[12] = 16'h1234;
        pulse_start();
        run_to_done(na, nb);
        chk("c2_mm", 32'(mm_a), 32'(CHK));
        chk("c2_idx_a", 32'(mmi_a), CHK ? 32'd3 : 32'd0);
        chk("c2_idx_b", 32'(mmi_b), CHK ? 32'd3 : 32'd0);

        // Reset mid-scan at rsel=5
        load_fib();
        pulse_start();
        n = 0;
        while (rsel_a != 4'd5 && n < 60) begin
            tick();
            n++;
        end
        chk("reach_r5", 32'(rsel_a), 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_busy", 32'(busy_a), 32'd0);
        chk("mr_done", 32'(done_a), 32'd0);
        chk("mr_val", 32'(sv_a), 32'd0);
        chk("mr_rsel_b", 32'(rsel_b), 32'd0);
        pulse_start();
        chk("rs_rsel", 32'(rsel_a), 32'd0);
        chk("rs_busy", 32'(busy_a), 32'd1);
        run_to_done(na, nb);
        chk("rs_done_a", 32'(na), 32'd48);

        // Start while busy is ignored
        pulse_start();
        n = 0;
        pulsed = 1'b0;
        for (int t = 0; t < 120; t++) begin
            if (rsel_a == 4'd4 && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            tick();
            start = 1'b0;
            n++;
            if (done_a) break;
        end
        chk("swb_done", 32'(n), 32'd48);

        // Random scans with stray starts and occasional resets
        for (int s = 0; s < 12; s++) begin
            wait_idle();
            for (int i = 0; i < 16; i++) begin
                mem[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                     : fib(i);
            end
            pulse_start();
            for (int t = 0; t < $urandom_range(20, 60); t++) begin
                start = ($urandom_range(0, 15) == 0);
                reset = ($urandom_range(0, 79) == 0);
                tick();
            end
            start = 1'b0;
            reset = 1'b0;
        end
        wait_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
